// File: rtl/map_rom_arbiter.sv
// map_rom_arbiter: shares the 8x8 map ROM between the player,
// raycaster and minimap requesters with in-order read return.
module map_rom_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 2,
  parameter int ROM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_req,
  input  logic [ADDR_W-1:0] p_addr,
  output logic              p_gnt,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              r_req,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              r_gnt,
  output logic              r_rvalid,
  output logic [DATA_W-1:0] r_rdata,
  input  logic              m_req,
  input  logic [ADDR_W-1:0] m_addr,
  output logic              m_gnt,
  output logic              m_rvalid,
  output logic [DATA_W-1:0] m_rdata,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_data
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam int PD = ROM_LAT + 1;

  localparam logic [1:0] ID_P = 2'd0;
  localparam logic [1:0] ID_R = 2'd1;
  localparam logic [1:0] ID_M = 2'd2;

  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      m_cnt;
  logic               ptr_m;
  logic               sr;
  logic               sm;
  logic               g_p;
  logic               g_r;
  logic               g_m;
  logic               xfer;
  logic [ADDR_W-1:0]  sel_addr;
  logic [1:0]         sel_id;
  logic [PD-1:0]      tag_v;
  logic [PD-1:0][1:0] tag_id;
  logic               p_hit;
  logic               r_hit;
  logic               m_hit;
  logic [DATA_W-1:0]  p_hold;
  logic [DATA_W-1:0]  r_hold;
  logic [DATA_W-1:0]  m_hold;

  assign sr = r_req && (r_cnt == SMAX);
  assign sm = m_req && (m_cnt == SMAX);

  // Pick one winner: starved 1/2 first, then player, then RR.
  always_comb begin
    g_p = 1'b0;
    g_r = 1'b0;
    g_m = 1'b0;
    if (!rst) begin
      if (sr && sm) begin
        g_r = !ptr_m;
        g_m = ptr_m;
      end else if (sr) begin
        g_r = 1'b1;
      end else if (sm) begin
        g_m = 1'b1;
      end else if (p_req) begin
        g_p = 1'b1;
      end else if (r_req && m_req) begin
        g_r = !ptr_m;
        g_m = ptr_m;
      end else if (r_req) begin
        g_r = 1'b1;
      end else if (m_req) begin
        g_m = 1'b1;
      end
    end
  end

  assign p_gnt = g_p;
  assign r_gnt = g_r;
  assign m_gnt = g_m;
  assign xfer  = g_p || g_r || g_m;

  // Route the winning address and its owner id to the issue stage.
  always_comb begin
    sel_addr = p_addr;
    sel_id   = ID_P;
    if (g_r) begin
      sel_addr = r_addr;
      sel_id   = ID_R;
    end else if (g_m) begin
      sel_addr = m_addr;
      sel_id   = ID_M;
    end
  end

  // RR pointer flips after every port 1/2 grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_m <= 1'b0;
    end else if (g_r) begin
      ptr_m <= 1'b1;
    end else if (g_m) begin
      ptr_m <= 1'b0;
    end
  end

  // Raycaster starvation count, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!r_req || g_r) begin
      r_cnt <= '0;
    end else if (r_cnt != SMAX) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  // Minimap starvation count, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= '0;
    end else if (!m_req || g_m) begin
      m_cnt <= '0;
    end else if (m_cnt != SMAX) begin
      m_cnt <= m_cnt + ONE;
    end
  end

  // Register the ROM request; address holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr <= '0;
      rom_en   <= 1'b0;
    end else begin
      rom_en <= xfer;
      if (xfer) begin
        rom_addr <= sel_addr;
      end
    end
  end

  // Owner tags ride alongside the ROM access, in order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v  <= {tag_v[PD-2:0], xfer};
      tag_id <= {tag_id[PD-2:0], sel_id};
    end
  end

  assign p_hit = tag_v[PD-1] && (tag_id[PD-1] == ID_P);
  assign r_hit = tag_v[PD-1] && (tag_id[PD-1] == ID_R);
  assign m_hit = tag_v[PD-1] && (tag_id[PD-1] == ID_M);

  // Keep each port's last returned cell for idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_hold <= '0;
      r_hold <= '0;
      m_hold <= '0;
    end else begin
      if (p_hit) p_hold <= rom_data;
      if (r_hit) r_hold <= rom_data;
      if (m_hit) m_hold <= rom_data;
    end
  end

  assign p_rvalid = p_hit;
  assign r_rvalid = r_hit;
  assign m_rvalid = m_hit;
  assign p_rdata  = p_hit ? rom_data : p_hold;
  assign r_rdata  = r_hit ? rom_data : r_hold;
  assign m_rdata  = m_hit ? rom_data : m_hold;

endmodule

// File: tb/tb_map_rom_arbiter.sv
// tb_map_rom_arbiter: directed steps with a return scoreboard
// for the three-port map ROM arbiter.
module tb_map_rom_arbiter;

  localparam int AW = 6;
  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p_req = 1'b0;
  logic          r_req = 1'b0;
  logic          m_req = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [AW-1:0] r_addr = '0;
  logic [AW-1:0] m_addr = '0;
  logic          p_gnt, r_gnt, m_gnt;
  logic          p_rvalid, r_rvalid, m_rvalid;
  logic [DW-1:0] p_rdata, r_rdata, m_rdata;
  logic [AW-1:0] rom_addr;
  logic          rom_en;
  logic [DW-1:0] rom_data = '0;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  typedef struct packed {
    logic [1:0] port;
    logic [1:0] data;
  } exp_t;

  exp_t sbq[$];

  map_rom_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_addr(p_addr), .p_gnt(p_gnt),
    .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .r_req(r_req), .r_addr(r_addr), .r_gnt(r_gnt),
    .r_rvalid(r_rvalid), .r_rdata(r_rdata),
    .m_req(m_req), .m_addr(m_addr), .m_gnt(m_gnt),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  // one-cycle ROM whose cell code is the low address bits
  always @(posedge clk) rom_data <= rom_addr[1:0];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] port, input logic [AW-1:0] a);
    exp_t e;
    e.port = port;
    e.data = a[1:0];
    sbq.push_back(e);
  endtask

  task automatic sb();
    logic [2:0] rv;
    logic [1:0] d;
    exp_t e;
    rv = {m_rvalid, r_rvalid, p_rvalid};
    if (rv != 3'b000) begin
      if (sbq.size() == 0) begin
        chk("sb_spurious", 32'(rv), 32'd0);
      end else begin
        e = sbq.pop_front();
        d = (e.port == 2'd0) ? p_rdata :
            (e.port == 2'd1) ? r_rdata : m_rdata;
        chk("sb_port", 32'(rv), 32'(3'b001 << e.port));
        chk("sb_data", 32'(d), 32'(e.data));
      end
    end
  endtask

  task automatic next();
    @(posedge clk);
    @(negedge clk);
    sb();
  endtask

  task automatic gnts(input string tag, input logic [2:0] exp);
    #1;
    chk(tag, 32'({m_gnt, r_gnt, p_gnt}), 32'(exp));
  endtask

  task automatic drain(input string tag);
    repeat (4) next();
    chk(tag, 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    logic er;
    // reset values, grants masked while rst is high
    p_req = 1'b1;
    r_req = 1'b1;
    m_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", 32'({m_gnt, r_gnt, p_gnt}), 32'd0);
    chk("rst_en", 32'(rom_en), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_rv", 32'({m_rvalid, r_rvalid, p_rvalid}), 32'd0);
    chk("rst_rd", 32'({m_rdata, r_rdata, p_rdata}), 32'd0);
    p_req = 1'b0;
    r_req = 1'b0;
    m_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // single player read of cell 13
    p_req = 1'b1;
    p_addr = 6'd13;
    gnts("t1_gnt", 3'b001);
    push(2'd0, 6'd13);
    next();
    p_req = 1'b0;
    chk("t1_rom_addr", 32'(rom_addr), 32'd13);
    chk("t1_rom_en", 32'(rom_en), 32'd1);
    chk("t1_rv_early", 32'(p_rvalid), 32'd0);
    next();
    chk("t1_p_rvalid", 32'(p_rvalid), 32'd1);
    chk("t1_p_rdata", 32'(p_rdata), 32'd1);
    next();
    chk("t1_en_off", 32'(rom_en), 32'd0);
    chk("t1_p_hold", 32'(p_rdata), 32'd1);
    drain("t1_empty");

    // all three at once: p, then r, then m
    p_req = 1'b1; p_addr = 6'd4;
    r_req = 1'b1; r_addr = 6'd9;
    m_req = 1'b1; m_addr = 6'd14;
    gnts("t2_g0", 3'b001);
    push(2'd0, 6'd4);
    next();
    p_req = 1'b0;
    gnts("t2_g1", 3'b010);
    push(2'd1, 6'd9);
    next();
    r_req = 1'b0;
    gnts("t2_g2", 3'b100);
    push(2'd2, 6'd14);
    chk("t2_p_rv", 32'(p_rvalid), 32'd1);
    next();
    m_req = 1'b0;
    chk("t2_r_rv", 32'(r_rvalid), 32'd1);
    next();
    chk("t2_m_rv", 32'(m_rvalid), 32'd1);
    chk("t2_m_rd", 32'(m_rdata), 32'd2);
    drain("t2_empty");

    // r and m continuous: strict alternation, no rom_en gap
    r_req = 1'b1; r_addr = 6'd1;
    m_req = 1'b1; m_addr = 6'd22;
    for (int i = 0; i < 8; i++) begin
      er = (i % 2 == 0);
      gnts($sformatf("t3_g%0d", i), er ? 3'b010 : 3'b100);
      if (er) push(2'd1, r_addr);
      else push(2'd2, m_addr);
      if (i > 0) chk("t3_en", 32'(rom_en), 32'd1);
      next();
      if (er) r_addr = r_addr + 6'd5;
      else m_addr = m_addr + 6'd7;
    end
    r_req = 1'b0;
    m_req = 1'b0;
    drain("t3_empty");

    // starvation: r breaks through every fifth cycle
    p_req = 1'b1; p_addr = 6'd3;
    r_req = 1'b1; r_addr = 6'd40;
    for (int k = 0; k < 15; k++) begin
      er = (k % 5 == 4);
      gnts($sformatf("t4_g%0d", k), er ? 3'b010 : 3'b001);
      if (er) push(2'd1, r_addr);
      else push(2'd0, p_addr);
      next();
      if (er) r_addr = r_addr + 6'd1;
      else p_addr = p_addr + 6'd1;
    end
    p_req = 1'b0;
    r_req = 1'b0;
    drain("t4_empty");

    // reset with an r access in flight
    m_req = 1'b1; m_addr = 6'd5;
    gnts("t5_gm", 3'b100);
    push(2'd2, 6'd5);
    next();
    m_req = 1'b0;
    r_req = 1'b1; r_addr = 6'd7;
    gnts("t5_gr", 3'b010);
    next();
    r_req = 1'b0;
    p_req = 1'b1;
    rst = 1'b1;
    #1;
    chk("t5_rst_gnt", 32'(p_gnt), 32'd0);
    chk("t5_rst_en", 32'(rom_en), 32'd0);
    chk("t5_rst_addr", 32'(rom_addr), 32'd0);
    chk("t5_rst_rd", 32'({m_rdata, r_rdata, p_rdata}), 32'd0);
    next();
    chk("t5_no_rv", 32'({m_rvalid, r_rvalid, p_rvalid}), 32'd0);
    rst = 1'b0;
    p_req = 1'b0;
    r_req = 1'b1; r_addr = 6'd10;
    m_req = 1'b1; m_addr = 6'd11;
    gnts("t5_fresh_r", 3'b010);
    push(2'd1, 6'd10);
    next();
    r_req = 1'b0;
    chk("t5_fresh_addr", 32'(rom_addr), 32'd10);
    gnts("t5_fresh_m", 3'b100);
    push(2'd2, 6'd11);
    next();
    m_req = 1'b0;
    drain("t5_empty");

    // m withdraws before grant; its count must restart
    p_req = 1'b1; p_addr = 6'd2;
    m_req = 1'b1; m_addr = 6'd33;
    gnts("t6_g0", 3'b001);
    push(2'd0, 6'd2);
    next();
    p_req = 1'b0;
    m_req = 1'b0;
    gnts("t6_g1", 3'b000);
    next();
    chk("t6_en_off", 32'(rom_en), 32'd0);
    p_req = 1'b1; p_addr = 6'd0;
    m_req = 1'b1; m_addr = 6'd33;
    for (int k = 0; k < 5; k++) begin
      er = (k == 4);
      gnts($sformatf("t6_s%0d", k), er ? 3'b100 : 3'b001);
      if (er) push(2'd2, m_addr);
      else push(2'd0, p_addr);
      next();
      if (!er) p_addr = p_addr + 6'd1;
    end
    p_req = 1'b0;
    m_req = 1'b0;
    drain("t6_empty");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/map_rom_arbiter.md
Name: map_rom_arbiter

Overview:
- Shares the single synchronous 8x8 map ROM (64 cells, 2-bit cell code) between three requesters.
- Requesters: the player collision check (port 0), the raycaster wall march (port 1) and the minimap/HUD scanner (port 2).
- One ROM access can issue per clock. Read data returns to the owning port with fixed latency.
- Sits between the requesters and the map ROM instance.

Parameters:
ADDR_W, 6, ROM address width (y*8+x)
DATA_W, 2, cell code width
ROM_LAT, 1, ROM clock-to-data latency in cycles (1..3)
STARVE_MAX, 4, consecutive lost cycles before a port 1/2 request overrides port 0

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
p_req  in  1  player request
p_addr  in  ADDR_W  player cell address
p_gnt  out  1  player request accepted this cycle
p_rvalid  out  1  player read data valid (1-cycle pulse)
p_rdata  out  DATA_W  player read data
r_req / r_addr / r_gnt / r_rvalid / r_rdata  same as player, raycaster port
m_req / m_addr / m_gnt / m_rvalid / m_rdata  same as player, minimap port
rom_addr  out  ADDR_W  address to map ROM (registered)
rom_en  out  1  ROM read enable (registered)
rom_data  in  DATA_W  ROM output, valid ROM_LAT cycles after rom_addr/rom_en

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk.
- Reset values:
  - rom_addr=0, rom_en=0.
  - All rvalid=0, all rdata=0.
  - RR pointer set to port 1.
  - Starvation counters 1 and 2 cleared.
  - In-flight tag pipeline flushed.
- x_gnt is combinational from the current req inputs and registered state. It is held 0 while rst is high.
- Handshake: an access transfers in any cycle where x_req && x_gnt.
  - Requester holds x_addr stable while x_req is high and not granted.
  - Requester may withdraw req before grant.
  - Holding req high after a grant requests a new access (back-to-back allowed, with new addr).
- At most one gnt is high per cycle.
- Arbitration, evaluated every cycle over asserted reqs:
  1. Any port 1/2 with starve counter == STARVE_MAX wins. If both are starved, the RR pointer chooses.
  2. Otherwise, port 0 wins if requesting.
  3. Otherwise, ports 1/2 are chosen round-robin: the pointer port wins if requesting, else the other port.
- RR pointer moves to the other port (1<->2) after any grant to port 1 or 2. It is unchanged by port 0 grants.
- Starve counter for ports 1 and 2:
  - Increments (saturating at STARVE_MAX) each cycle the port's req is high and its gnt is low.
  - Clears on grant or when req is low.
- Issue: on the edge ending a transfer cycle T, rom_addr <= granted addr and rom_en <= 1. When there is no transfer, rom_en <= 0 and rom_addr holds.
- Return:
  - An owner tag (2-bit port id plus valid) is shifted through a 1+ROM_LAT deep pipeline.
  - At cycle T+1+ROM_LAT, the owner's rvalid=1 for one cycle and its rdata=rom_data.
  - Other ports' rvalid=0 and their rdata hold their last value.
- Throughput: 1 access/cycle sustained, with out-of-order return impossible (single in-order pipe).
- Address width: addr is used verbatim. All 64 values are legal, so there is no range checking.
- Reset mid-operation flushes all in-flight tags. No rvalid is produced for accesses issued before reset, even if rom_data changes.
- When no ports request, there is no grant, rom_en=0 next cycle, and counters/pointer hold.

Test Plan:
- Bench ROM model returns rom_data = addr[1:0], ROM_LAT=1.
- Single player read: p_req=1, p_addr=13 at T, others idle -> p_gnt=1 at T; rom_addr=13, rom_en=1 at T+1; p_rvalid=1, p_rdata=1 at T+2.
- All three request at T (addrs 4, 9, 14) and hold until granted:
  - grants p at T, r at T+1, m at T+2;
  - rvalid p/r/m at T+2/T+3/T+4 with data 0/1/2.
- r_req and m_req continuous, p idle:
  - grants alternate r, m, r, m starting with r after reset;
  - a 1-cycle rom_en gap never occurs.
- Starvation, STARVE_MAX=4: p_req and r_req continuous from T.
  - p granted T..T+3; r granted at T+4; p granted again at T+5.
  - r_gnt then recurs every 5 cycles.
- Reset mid-flight: grant r at T, assert rst during T+1 -> no r_rvalid at T+2; all outputs at reset values; first post-reset grant behaves as a fresh access.
- Withdrawal: m_req high at T while p wins, dropped at T+1 -> m never granted, m_rvalid never pulses, m starve counter returns to 0.
